pwm_6bit_signed_decoder: RTL and testbench

//  Receive side of the 6-bit signed PWM link: measures one PWM frame and recovers the signed level -15..+15.

---
 rtl/pwm_6bit_signed_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_pwm_6bit_signed_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_6bit_signed_decoder.sv
// Receive side of the 6-bit signed PWM link: measures one frame and recovers the level -15..+15.
// Optional build macro PWM_DEC_GLITCH_FILTER_EN adds a 3-sample majority filter on pwmIn.
module pwm_6bit_signed_decoder #(
  parameter int PWM_UNIT  = 100,
  parameter int PWM_STEPS = 15,
  parameter int LINK_LAG  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       pwmIn,
  output logic [5:0] valueOut,
  output logic       validOut,
  output logic       errOut,
  output logic       fullScale
);

  localparam int PWM_PERIOD = PWM_STEPS * PWM_UNIT;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int FILT_LAG = 2;
`else
  localparam int FILT_LAG = 0;
`endif
  localparam int CNT_W  = $clog2(PWM_PERIOD);
  localparam int SUB_W  = $clog2(PWM_UNIT);
  localparam int UNIT_W = $clog2(PWM_STEPS + 1);

  localparam logic [CNT_W-1:0]  FRAME_FIRST  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  FRAME_LAST   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0]  FRAME_PRESET = CNT_W'(PWM_PERIOD - LINK_LAG - FILT_LAG);
  localparam logic [SUB_W-1:0]  SUB_ZERO     = {SUB_W{1'b0}};
  localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(PWM_UNIT - 1);
  localparam logic [SUB_W-1:0]  SUB_HALF     = SUB_W'(PWM_UNIT / 2);
  localparam logic [UNIT_W-1:0] UNIT_ZERO    = {UNIT_W{1'b0}};
  localparam logic [UNIT_W-1:0] UNIT_FULL    = UNIT_W'(PWM_STEPS);
  localparam logic [5:0]        STEPS_V      = 6'(PWM_STEPS);

  typedef enum logic [0:0] {
    MEASURE = 1'b0,
    RESOLVE = 1'b1
  } state_t;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // round-half-up of the unit count, saturated to the frame length in units
  function automatic logic [5:0] round_units(input logic [UNIT_W-1:0] units,
                                             input logic [SUB_W-1:0]  sub);
    logic [5:0] r;
    r = 6'(units) + {5'b00000, (sub >= SUB_HALF)};
    if (r > STEPS_V) begin
      r = STEPS_V;
    end else begin
      r = r;
    end
    return r;
  endfunction

  logic sample_s;

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic [2:0] filt_q;

  // line history for the majority vote
  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt_q <= 3'b000;
    end else begin
      filt_q <= {filt_q[1:0], pwmIn};
    end
  end

  assign sample_s = majority3(filt_q);
`else
  assign sample_s = pwmIn;
`endif

  state_t            state_q;
  logic [CNT_W-1:0]  frameCnt_q,  frameCnt_d;
  logic [SUB_W-1:0]  subCnt_q,    subCnt_d;
  logic [UNIT_W-1:0] unitCnt_q,   unitCnt_d;
  logic              firstHi_q,   firstHi_d;
  logic              lastHi_q,    lastHi_d;
  logic              primed_q;
  logic              resolveEn_q;
  logic [5:0]        value_q,     value_d;
  logic              valid_q,     valid_d;
  logic              err_q,       err_d;
  logic              full_q,      full_d;

  logic [SUB_W-1:0]  subBase_s;
  logic [UNIT_W-1:0] unitBase_s;
  logic [5:0]        units_s;
  logic              zeroCnt_s;
  logic              fullCnt_s;

  // frame position and high-cycle accumulation; RESOLVE restarts with the new frame's sample 0
  always_comb begin
    if (frameCnt_q == FRAME_LAST) begin
      frameCnt_d = FRAME_FIRST;
    end else begin
      frameCnt_d = frameCnt_q + CNT_W'(1);
    end

    if (state_q == RESOLVE) begin
      subBase_s  = SUB_ZERO;
      unitBase_s = UNIT_ZERO;
    end else begin
      subBase_s  = subCnt_q;
      unitBase_s = unitCnt_q;
    end

    if (sample_s && (subBase_s == SUB_LAST)) begin
      subCnt_d  = SUB_ZERO;
      unitCnt_d = unitBase_s + UNIT_W'(1);
    end else if (sample_s) begin
      subCnt_d  = subBase_s + SUB_W'(1);
      unitCnt_d = unitBase_s;
    end else begin
      subCnt_d  = subBase_s;
      unitCnt_d = unitBase_s;
    end

    if (frameCnt_q == FRAME_FIRST) begin
      firstHi_d = sample_s;
    end else begin
      firstHi_d = firstHi_q;
    end

    if (frameCnt_q == FRAME_LAST) begin
      lastHi_d = sample_s;
    end else begin
      lastHi_d = lastHi_q;
    end
  end

  // frame classification, evaluated while RESOLVE holds the completed frame's counts
  always_comb begin
    units_s   = round_units(unitCnt_q, subCnt_q);
    zeroCnt_s = (unitCnt_q == UNIT_ZERO) && (subCnt_q == SUB_ZERO);
    fullCnt_s = (unitCnt_q == UNIT_FULL) && (subCnt_q == SUB_ZERO);
    value_d   = value_q;
    err_d     = err_q;
    full_d    = full_q;
    valid_d   = 1'b0;

    if ((state_q == RESOLVE) && resolveEn_q) begin
      valid_d = 1'b1;
      err_d   = 1'b0;
      full_d  = 1'b0;
      if (zeroCnt_s) begin
        value_d = 6'd0;
      end else if (fullCnt_s) begin
        value_d = STEPS_V;
        full_d  = 1'b1;
      end else if (units_s == 6'd0) begin
        value_d = 6'd0;
      end else begin
        case ({firstHi_q, lastHi_q})
          2'b10:   value_d = units_s;
          2'b01:   value_d = 6'd0 - units_s;
          default: err_d   = 1'b1;
        endcase
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // FSM, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= MEASURE;
      frameCnt_q  <= FRAME_PRESET;
      subCnt_q    <= SUB_ZERO;
      unitCnt_q   <= UNIT_ZERO;
      firstHi_q   <= 1'b0;
      lastHi_q    <= 1'b0;
      primed_q    <= 1'b0;
      resolveEn_q <= 1'b0;
      value_q     <= 6'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      frameCnt_q <= frameCnt_d;
      subCnt_q   <= subCnt_d;
      unitCnt_q  <= unitCnt_d;
      firstHi_q  <= firstHi_d;
      lastHi_q   <= lastHi_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      full_q     <= full_d;
      case (state_q)
        MEASURE: begin
          if (frameCnt_q == FRAME_LAST) begin
            state_q     <= RESOLVE;
            // the frame cut short by RESET is never reported
            resolveEn_q <= primed_q;
            primed_q    <= 1'b1;
          end
        end
        RESOLVE: begin
          state_q <= MEASURE;
        end
        default: begin
          state_q <= MEASURE;
        end
      endcase
    end
  end

  assign valueOut  = value_q;
  assign validOut  = valid_q;
  assign errOut    = err_q;
  assign fullScale = full_q;

endmodule

// File: tb/tb_pwm_6bit_signed_decoder.sv
// Bench for pwm_6bit_signed_decoder: directed and random frames against a frame-level model.
module tb_pwm_6bit_signed_decoder;

  localparam int UNIT  = 100;
  localparam int STEPS = 15;
  localparam int P     = UNIT * STEPS;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       pwmIn;
  logic [5:0] valueOut;
  logic       validOut;
  logic       errOut;
  logic       fullScale;

  int checks = 0;
  int errors = 0;

  bit         pending = 1'b0;
  string      exp_tag = "none";
  logic [5:0] exp_value = 6'd0;
  bit         exp_err = 1'b0;
  bit         exp_full = 1'b0;
  logic [5:0] held_value = 6'd0;

  pwm_6bit_signed_decoder #(
    .PWM_UNIT (UNIT),
    .PWM_STEPS(STEPS),
    .LINK_LAG (1)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .pwmIn    (pwmIn),
    .valueOut (valueOut),
    .validOut (validOut),
    .errOut   (errOut),
    .fullScale(fullScale)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v);
    pwmIn = v;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [P-1:0] pulse(input int a, input int b);
    logic [P-1:0] f;
    f = '0;
    for (int i = 0; i < P; i++) begin
      if (i >= a && i <= b) f[i] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [P-1:0] level(input int l);
    if (l > 0)      return pulse(0, l * UNIT - 1);
    else if (l < 0) return pulse(P + l * UNIT, P - 1);
    else            return pulse(1, 0);
  endfunction

  // expected decode of a whole frame from its high count and end samples
  task automatic model_frame(input string tag, input logic [P-1:0] f);
    int cnt;
    int units;
    cnt = 0;
    for (int i = 0; i < P; i++) cnt += int'(f[i]);
    units = (cnt + UNIT / 2) / UNIT;
    if (units > STEPS) units = STEPS;
    exp_err  = 1'b0;
    exp_full = 1'b0;
    if (cnt == 0)                 exp_value = 6'd0;
    else if (cnt == P) begin
      exp_value = 6'(STEPS);
      exp_full  = 1'b1;
    end
    else if (units == 0)          exp_value = 6'd0;
    else if (f[0] && !f[P-1])     exp_value = 6'(units);
    else if (!f[0] && f[P-1])     exp_value = 6'(-units);
    else begin
      exp_err   = 1'b1;
      exp_value = held_value;
    end
    held_value = exp_value;
    pending    = 1'b1;
    exp_tag    = tag;
  endtask

  // drives a frame; the previous frame's result must appear exactly at its first sample
  task automatic send_frame(input string tag, input logic [P-1:0] f, input int stop_at);
    int strays;
    strays = 0;
    for (int i = 0; i < stop_at; i++) begin
      tick(f[i]);
      if (i == 0) begin
        chk({exp_tag, " validOut"}, int'(validOut), int'(pending));
        if (pending) begin
          chk({exp_tag, " valueOut"}, int'(valueOut), int'(exp_value));
          chk({exp_tag, " errOut"}, int'(errOut), int'(exp_err));
          chk({exp_tag, " fullScale"}, int'(fullScale), int'(exp_full));
        end
        pending = 1'b0;
      end else if (validOut) begin
        strays++;
      end
    end
    chk({tag, " stray validOut"}, strays, 0);
    if (stop_at == P) model_frame(tag, f);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    pwmIn = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
    chk("reset valueOut", int'(valueOut), 0);
    chk("reset validOut", int'(validOut), 0);
    chk("reset errOut", int'(errOut), 0);
    chk("reset fullScale", int'(fullScale), 0);
    RESET      = 1'b0;
    pending    = 1'b0;
    held_value = 6'd0;
    exp_tag    = "reset";
    tick(1'b0);
    chk("post-reset validOut", int'(validOut), 0);
  endtask

  initial begin
    logic [P-1:0] f;
    int k;
    int a;
    int n;
    RESET = 1'b1;
    pwmIn = 1'b0;
    do_reset(3);

    send_frame("lvl+5a", level(5), P);
    send_frame("lvl+5b", level(5), P);
    send_frame("lvl-3", level(-3), P);
    send_frame("lvl0", level(0), P);
    send_frame("lvl+15", level(15), P);
    send_frame("lvl-15", level(-15), P);
    send_frame("left149", pulse(0, 148), P);
    send_frame("left150", pulse(0, 149), P);
    send_frame("right40", pulse(P - 40, P - 1), P);
    send_frame("lvl+5c", level(5), P);
    send_frame("mid600", pulse(600, 799), P);
    send_frame("wrap", pulse(0, 99) | pulse(P - 100, P - 1), P);
    send_frame("spike", pulse(700, 700), P);
    send_frame("right1450", pulse(50, P - 1), P);

    for (int r = 0; r < 14; r++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: f = level(int'($urandom_range(0, 30)) - 15);
        1: begin
          n = int'($urandom_range(1, P - 1));
          f = pulse(0, n - 1);
        end
        2: begin
          n = int'($urandom_range(1, P - 1));
          f = pulse(P - n, P - 1);
        end
        default: begin
          a = int'($urandom_range(1, 1000));
          f = pulse(a, a + int'($urandom_range(0, 400)));
        end
      endcase
      send_frame($sformatf("rand%0d", r), f, P);
    end

    send_frame("lvl+4 cut", level(4), 700);
    do_reset(3);
    send_frame("lvl-7", level(-7), P);
    send_frame("flush", level(0), P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
